// File: rtl/fp_result_axis_tx.sv
// fp_result_axis_tx
// Output stage of the FP32 multiplier. Each strobed product is classified
// (zero / subnormal / infinity / NaN), stored with its class flags in a small
// first-word-fall-through FIFO and sent out as an AXI4-Stream master. tlast
// is asserted every PKT_LEN beats. A product that arrives while the FIFO is
// full is dropped, and the sticky overflow flag records the loss.
//
// Parameters:
//   DEPTH    FIFO entries (power of two, >= 2)
//   PKT_LEN  beats per packet, i.e. the tlast period (>= 1)
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   in_valid       product strobe; in_data is valid this cycle
//   in_data        FP32 product
//   in_ready       FIFO can accept a word this cycle
//   overflow       sticky flag: a strobed product was dropped (cleared by rst)
//   fill           FIFO occupancy, 0..DEPTH
//   m_axis_tdata   product at FIFO head
//   m_axis_tuser   head class flags: [0] zero [1] subnormal [2] inf [3] NaN
//   m_axis_tvalid  FIFO non-empty
//   m_axis_tready  consumer accepts the head word
//   m_axis_tlast   head beat is the last beat of a packet
module fp_result_axis_tx #(
    parameter int DEPTH   = 4,
    parameter int PKT_LEN = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [31:0]                in_data,
    output logic                       in_ready,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     fill,
    output logic [31:0]                m_axis_tdata,
    output logic [3:0]                 m_axis_tuser,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

    localparam logic [AW:0]   FULL_LVL = DEPTH[AW:0];
    localparam logic [CW-1:0] LAST_BEAT = CW'(PKT_LEN - 1);

    // Each entry holds {class flags, product}.
    logic [35:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] beat_cnt;

    logic [7:0]    exp_f;
    logic [22:0]   man_f;
    logic [3:0]    in_class;
    logic          wr_en;
    logic          rd_en;

    // Classification of the incoming word; the sign bit does not matter.
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        exp_f    = in_data[30:23];
        man_f    = in_data[22:0];
        in_class = 4'b0000;
        if (exp_f == 8'h00) begin
            if (man_f == 23'd0) in_class[0] = 1'b1;
            else                in_class[1] = 1'b1;
        end else if (exp_f == 8'hFF) begin
            if (man_f == 23'd0) in_class[2] = 1'b1;
            else                in_class[3] = 1'b1;
        end
    end

    // Full and empty come from fill alone, so a read freeing a slot on the
    // same edge never lets a word pass through a full FIFO.
    assign in_ready      = !rst && (fill != FULL_LVL);
    assign m_axis_tvalid = !rst && (fill != '0);
    assign m_axis_tdata  = mem[rd_ptr][31:0];
    assign m_axis_tuser  = mem[rd_ptr][35:32];
    assign m_axis_tlast  = m_axis_tvalid && (beat_cnt == LAST_BEAT);

    assign wr_en = in_valid && in_ready;
    assign rd_en = m_axis_tvalid && m_axis_tready;

    // NOTE: the storage array has no reset; fill decides what is valid, and
    // leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {in_class, in_data};
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, whatever order the statements are in.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            beat_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;

            case ({wr_en, rd_en})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase

            // Packet position follows accepted beats only, so a packet may
            // stall across an empty FIFO and resume later.
            if (rd_en) begin
                if (m_axis_tlast) beat_cnt <= '0;
                else              beat_cnt <= beat_cnt + 1'b1;
            end

            if (in_valid && !in_ready) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fp_result_axis_tx.sv
// Testbench for fp_result_axis_tx: directed vectors, with a scoreboard queue
// filled by the stimulus and drained by an independent output monitor.
module tb_fp_result_axis_tx;

    localparam int DEPTH   = 4;
    localparam int PKT_LEN = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        overflow;
    logic [2:0]  fill;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tuser;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;

    fp_result_axis_tx #(.DEPTH(DEPTH), .PKT_LEN(PKT_LEN)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .overflow      (overflow),
        .fill          (fill),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected output words in order: {tuser, tdata}.
    logic [35:0] sb[$];
    int          exp_beat  = 0;
    int          tlast_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d, input logic [3:0] u);
        sb.push_back({u, d});
    endtask

    // Monitor: samples on the falling edge, where a handshake seen now is the
    // one the next rising edge will complete.
    always @(negedge clk) begin
        logic [35:0] e;
        logic        want_last;
        if (rst) begin
            exp_beat = 0;
        end else if (m_axis_tvalid && m_axis_tready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got 0x%08h, expected no output at %0t",
                         m_axis_tdata, $time);
            end else begin
                e = sb.pop_front();
                check("tdata", m_axis_tdata, e[31:0]);
                check("tuser", {28'd0, m_axis_tuser}, {28'd0, e[35:32]});
            end
            want_last = (exp_beat == PKT_LEN - 1);
            check("tlast", {31'd0, m_axis_tlast}, {31'd0, want_last});
            if (want_last) begin
                exp_beat = 0;
                tlast_cnt++;
            end else begin
                exp_beat++;
            end
        end
    end

    // Classification vectors: {tuser, data}.
    logic [35:0] cls_vec [5] = '{
        {4'b0001, 32'h0000_0000},
        {4'b0010, 32'h0000_0001},
        {4'b0100, 32'h7F80_0000},
        {4'b1000, 32'h7FC0_0000},
        {4'b0000, 32'h3F80_0000}
    };

    initial begin
        logic [31:0] hold_data;
        logic [3:0]  hold_user;
        logic        hold_last;
        int          t0;
        int          guard;

        rst           = 1'b1;
        in_valid      = 1'b0;
        in_data       = '0;
        m_axis_tready = 1'b0;

        // 1. Reset / idle
        repeat (3) tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("rst_tlast", {31'd0, m_axis_tlast}, 32'd0);
        check("rst_fill", {29'd0, fill}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("idle_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("idle_fill", {29'd0, fill}, 32'd0);

        // 2. Classification, one-cycle latency
        m_axis_tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = cls_vec[i][31:0];
            push_word(cls_vec[i][31:0], cls_vec[i][35:32]);
            tick();
            check("cls_latency_valid", {31'd0, m_axis_tvalid}, 32'd1);
            check("cls_latency_data", m_axis_tdata, cls_vec[i][31:0]);
        end
        in_valid = 1'b0;
        tick();
        check("cls_drained", {29'd0, fill}, 32'd0);

        // 3. Full / overflow
        m_axis_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h4000_0000 + i;
            if (i < DEPTH) push_word(32'h4000_0000 + i, 4'b0000);
            tick();
            if (i == DEPTH - 1) begin
                check("full_fill", {29'd0, fill}, 32'd4);
                check("full_in_ready", {31'd0, in_ready}, 32'd0);
                check("full_no_overflow_yet", {31'd0, overflow}, 32'd0);
            end
        end
        in_valid = 1'b0;
        check("drop_overflow", {31'd0, overflow}, 32'd1);
        check("drop_fill", {29'd0, fill}, 32'd4);
        m_axis_tready = 1'b1;
        repeat (4) tick();
        check("drain_fill", {29'd0, fill}, 32'd0);
        check("overflow_sticky", {31'd0, overflow}, 32'd1);

        // 4. Back-pressure stability
        m_axis_tready = 1'b0;
        in_valid      = 1'b1;
        in_data       = 32'h3F80_0000;
        push_word(32'h3F80_0000, 4'b0000);
        tick();
        in_valid  = 1'b0;
        hold_data = m_axis_tdata;
        hold_user = m_axis_tuser;
        hold_last = m_axis_tlast;
        check("stall_head", m_axis_tdata, 32'h3F80_0000);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall_tdata", m_axis_tdata, hold_data);
            check("stall_tuser", {28'd0, m_axis_tuser}, {28'd0, hold_user});
            check("stall_tlast", {31'd0, m_axis_tlast}, {31'd0, hold_last});
            check("stall_fill", {29'd0, fill}, 32'd1);
        end
        m_axis_tready = 1'b1;
        tick();
        check("stall_release_fill", {29'd0, fill}, 32'd0);

        // Fresh packet alignment for the packet tests.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("overflow_cleared", {31'd0, overflow}, 32'd0);

        // 5. Packetisation with simultaneous read/write
        t0 = tlast_cnt;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h4100_0000 + i;
            push_word(32'h4100_0000 + i, 4'b0000);
            tick();
            check("stream_fill_le1", {31'd0, (fill <= 3'd1)}, 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("pkt_tlast_count", tlast_cnt - t0, 32'd2);
        // Beat count should now be 4: the 4th further beat closes the packet.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h4200_0000 + i;
            push_word(32'h4200_0000 + i, 4'b0000);
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("pkt_beatcnt4_tlast", tlast_cnt - t0, 32'd3);

        // 6. Reset mid-packet
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h4300_0000 + i;
            if (i < 3) push_word(32'h4300_0000 + i, 4'b0000);
            tick();
        end
        m_axis_tready = 1'b0;
        in_data       = 32'h4300_0004;
        tick();
        in_valid = 1'b0;
        check("midpkt_fill", {29'd0, fill}, 32'd2);
        rst = 1'b1;
        tick();
        check("midpkt_rst_fill", {29'd0, fill}, 32'd0);
        check("midpkt_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        rst           = 1'b0;
        m_axis_tready = 1'b1;
        t0 = tlast_cnt;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h4400_0000 + i;
            push_word(32'h4400_0000 + i, 4'b0000);
            tick();
            if (i == 6) check("midpkt_no_early_tlast", tlast_cnt - t0, 32'd0);
        end
        in_valid = 1'b0;
        tick();
        check("midpkt_tlast_8th", tlast_cnt - t0, 32'd1);

        // Drain whatever remains, bounded.
        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            tick();
            guard++;
        end
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_result_axis_tx.md
Name: fp_result_axis_tx

Overview:
- Downstream stage of the FP32 multiplier. Captures each 32-bit IEEE-754 single-precision product on a valid strobe.
- Classifies each product (zero / subnormal / infinity / NaN) and buffers it in a small FIFO.
- Emits the buffered products as an AXI4-Stream master, asserting tlast every PKT_LEN beats.
- Decouples the fixed-rate multiplier output from a back-pressuring stream consumer; flags lost results.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- PKT_LEN, 8, beats per packet (tlast period); minimum 1.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  product strobe from the multiplier; in_data valid this cycle.
- in_data  in  32  FP32 product (sign[31], exponent[30:23], mantissa[22:0]).
- in_ready  out  1  FIFO can accept a word this cycle.
- overflow  out  1  sticky: a strobed product was dropped because the FIFO was full.
- fill  out  clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- m_axis_tdata  out  32  product at FIFO head.
- m_axis_tuser  out  4  class flags of head word: [0] zero, [1] subnormal, [2] inf, [3] NaN.
- m_axis_tvalid  out  1  FIFO non-empty.
- m_axis_tready  in  1  consumer accepts.
- m_axis_tlast  out  1  head beat is the last beat of a packet.

Behaviour:
- Reset is clk/rst only: synchronous, active-high.
- State cleared by reset: rd_ptr, wr_ptr, fill, beat_cnt and overflow all go to 0.
- Outputs during and after reset:
  - m_axis_tvalid=0 and m_axis_tlast=0.
  - in_ready=0 while rst is high; in_ready=1 the first cycle after rst deasserts.
  - FIFO storage is not cleared; tdata/tuser are don't-care while tvalid=0.
- Reset mid-packet discards all buffered words and the partial packet count; the next accepted output beat is beat 0.
- Classification is combinational on in_data at write time and stored alongside the data (36-bit entry). With exp=in_data[30:23] and man=in_data[22:0]:
  - zero = (exp==0 && man==0)
  - subnormal = (exp==0 && man!=0)
  - inf = (exp==8'hFF && man==0)
  - NaN = (exp==8'hFF && man!=0)
  - Normal numbers give tuser=4'b0000. At most one flag is set. The sign bit is ignored.
- Input side:
  - in_ready = !rst && (fill != DEPTH).
  - Write occurs when in_valid && in_ready: entry stored at wr_ptr, then wr_ptr increments modulo DEPTH.
  - in_valid && !in_ready && !rst: the word is dropped, FIFO is unchanged, and overflow is set to 1 on that edge. overflow clears only on rst.
- Output side (first-word-fall-through):
  - m_axis_tvalid = (fill != 0).
  - tdata/tuser are read from mem[rd_ptr].
  - A word written on edge k is presented with tvalid=1 in the cycle after edge k (1-cycle latency, empty to valid).
- Read occurs when tvalid && tready: rd_ptr increments modulo DEPTH.
- Fill update per edge: +1 on write only, -1 on read only, unchanged on simultaneous write and read.
  - Simultaneous write and read is legal whenever fill is between 1 and DEPTH-1.
  - At fill==DEPTH, in_ready=0, so no write occurs even if a read occurs on the same edge (no pass-through).
  - At fill==0 there is no read.
- Stability: while tvalid && !tready, tdata, tuser and tlast must hold constant (the head does not move).
- Packetisation:
  - beat_cnt counts accepted output beats, 0..PKT_LEN-1.
  - m_axis_tlast = tvalid && (beat_cnt == PKT_LEN-1).
  - On a handshake beat_cnt increments; on a handshake with tlast it wraps to 0.
  - PKT_LEN=1 gives tlast on every beat.
  - Packet boundaries are independent of FIFO emptiness; a packet may stall mid-way.
- Pointer wrap: DEPTH is a power of two, so pointers are clog2(DEPTH) bits and wrap naturally. Full/empty are determined by fill, not pointer compare.
- Throughput: one word per cycle sustained when tready is held high.

Test Plan:
1. Reset/idle. Drive rst=1 for 3 cycles, then release with no input. Required: tvalid=0, tlast=0, fill=0, overflow=0, in_ready=0 during rst and 1 after.
2. Classification. Stream 0x00000000, 0x00000001, 0x7F800000, 0x7FC00000, 0x3F800000 with tready=1. Required: tuser 0001, 0010, 0100, 1000, 0000 respectively; each word appears one cycle after its strobe.
3. Full/overflow. Set tready=0 and strobe 5 words 0x40000000..0x40000004 (DEPTH=4). Required:
   - fill reaches 4; in_ready=0 after the 4th write.
   - The 5th word is dropped and overflow goes to 1.
   - After tready=1, exactly 0x40000000..0x40000003 drain, in order.
   - overflow stays 1 until rst.
4. Back-pressure stability. Present 0x3F800000 and toggle tready 0,0,1. Required: tdata/tuser/tlast are unchanged across the stalled cycles; the handshake happens on the third cycle only.
5. Packetisation with simultaneous read/write. Send 20 words continuously with tready=1 (PKT_LEN=8). Required:
   - tlast on beats 8, 16.
   - beat_cnt is 4 after the last beat.
   - fill never exceeds 1.
6. Reset mid-packet. After 3 output beats with 2 words buffered, pulse rst. Required: FIFO empties, the buffered words are never output, and the next packet's tlast arrives on its 8th beat.
